// File: rtl/alarm_set.sv
// Alarm time setting block: debounced Mode/Up/Bell keys drive a small set-mode
// FSM that edits a packed-BCD alarm hour/minute, with auto-repeat and timeout.
module alarm_set #(
  parameter int DEB_MS  = 20,
  parameter int HOLD_MS = 1000,
  parameter int RPT_MS  = 250,
  parameter int TMO_MS  = 10000
) (
  input  logic       _1kHzIN,
  input  logic       nCR,
  input  logic       ModeKey,
  input  logic       UpKey,
  input  logic       BellKey,
  output logic [7:0] Set_Hr,
  output logic [7:0] Set_Min,
  output logic [1:0] SetActive,
  output logic       BellEn
);
  // state   | meaning
  // IDLE    | alarm time displayed, Up key ignored
  // SET_HR  | Up key increments hour 00..23
  // SET_MIN | Up key increments minute 00..59
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HR   = 2'b01;
  localparam logic [1:0] ST_MIN  = 2'b10;

  localparam int DW = $clog2(DEB_MS + 1);
  localparam int RW = $clog2(HOLD_MS + 1);
  localparam int TW = $clog2(TMO_MS + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEB_MS - 1);
  localparam logic [RW-1:0] RPT_HOLD = RW'(HOLD_MS);
  localparam logic [RW-1:0] RPT_LOAD = RW'(HOLD_MS - RPT_MS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_MS - 1);

  // nCR asserts asynchronously, releases two edges later
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge _1kHzIN or negedge nCR) begin
    if (!nCR) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // key index: 0 Mode, 1 Up, 2 Bell
  logic [2:0]    keys_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d, deb_dly_q;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];
  logic [2:0]    press;

  assign keys_raw = {BellKey, UpKey, ModeKey};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      db_cnt_d[k] = '0;
      deb_d[k]    = deb_q[k];
      if (sync2_q[k] != deb_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) deb_d[k]    = sync2_q[k];
        else                        db_cnt_d[k] = db_cnt_q[k] + DW'(1);
      end
    end
  end

  always_ff @(posedge _1kHzIN or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
    end
  end

  assign press = deb_q & ~deb_dly_q;

  // Up auto-repeat: count cycles since the press event, reload after each repeat
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_pulse;

  assign rpt_pulse = deb_q[1] && (rpt_cnt_q == RPT_HOLD);

  always_comb begin
    rpt_cnt_d = '0;
    if (deb_q[1]) rpt_cnt_d = rpt_pulse ? RPT_LOAD : rpt_cnt_q + RW'(1);
  end

  always_ff @(posedge _1kHzIN or negedge rst_n) begin
    if (!rst_n) rpt_cnt_q <= '0;
    else        rpt_cnt_q <= rpt_cnt_d;
  end

  logic          mode_ev, up_ev, bell_ev, any_ev, tmo_hit;
  logic [1:0]    state_q, state_d;
  logic [7:0]    hr_q, hr_d, min_q, min_d, hr_inc, min_inc;
  logic          bell_q, bell_d;
  logic [TW-1:0] tmo_q, tmo_d;

  assign mode_ev = press[0];
  assign up_ev   = press[1] | rpt_pulse;
  assign bell_ev = press[2];
  assign any_ev  = mode_ev | up_ev | bell_ev;
  assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TMO_LAST) && !any_ev;

  always_comb begin
    if (hr_q == 8'h23)          hr_inc = 8'h00;
    else if (hr_q[3:0] == 4'd9) hr_inc = {hr_q[7:4] + 4'd1, 4'd0};
    else                        hr_inc = {hr_q[7:4], hr_q[3:0] + 4'd1};

    if (min_q[3:0] != 4'd9)     min_inc = {min_q[7:4], min_q[3:0] + 4'd1};
    else if (min_q[7:4] == 4'd5) min_inc = 8'h00;
    else                        min_inc = {min_q[7:4] + 4'd1, 4'd0};
  end

  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    bell_d  = bell_ev ? ~bell_q : bell_q;
    tmo_d   = (state_q == ST_IDLE || any_ev) ? '0 : tmo_q + TW'(1);

    if (mode_ev) begin
      case (state_q)
        ST_IDLE: state_d = ST_HR;
        ST_HR:   state_d = ST_MIN;
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit || state_q == 2'b11) begin
      state_d = ST_IDLE;
    end else if (up_ev) begin
      if (state_q == ST_HR)  hr_d  = hr_inc;
      if (state_q == ST_MIN) min_d = min_inc;
    end
  end

  always_ff @(posedge _1kHzIN or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hr_q    <= 8'h00;
      min_q   <= 8'h00;
      bell_q  <= 1'b1;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      bell_q  <= bell_d;
      tmo_q   <= tmo_d;
    end
  end

  assign Set_Hr    = hr_q;
  assign Set_Min   = min_q;
  assign SetActive = state_q;
  assign BellEn    = bell_q;

endmodule

// File: tb/tb_alarm_set.sv
// Directed bench for alarm_set: debounce, hour/minute stepping, auto-repeat,
// timeout, bell toggle and reset behaviour at default (1 ms per cycle) timing.
module tb_alarm_set;
  logic       clk = 1'b0;
  logic       nCR, ModeKey, UpKey, BellKey;
  logic [7:0] Set_Hr, Set_Min;
  logic [1:0] SetActive;
  logic       BellEn;

  int n_chk  = 0;
  int n_fail = 0;

  alarm_set dut (
    ._1kHzIN  (clk),
    .nCR      (nCR),
    .ModeKey  (ModeKey),
    .UpKey    (UpKey),
    .BellKey  (BellKey),
    .Set_Hr   (Set_Hr),
    .Set_Min  (Set_Min),
    .SetActive(SetActive),
    .BellEn   (BellEn)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k: 0 Mode, 1 Up, 2 Bell
  task automatic set_key(input int k, input logic v);
    case (k)
      0: ModeKey = v;
      1: UpKey   = v;
      default: BellKey = v;
    endcase
  endtask

  task automatic press(input int k, input int hi, input int lo);
    set_key(k, 1'b1);
    tick(hi);
    set_key(k, 1'b0);
    tick(lo);
  endtask

  initial begin
    logic [7:0] exp_bcd;
    int v;
    bit found;

    nCR = 1'b0; ModeKey = 1'b0; UpKey = 1'b0; BellKey = 1'b0;
    tick(3);
    chk("rst_hr",   32'(Set_Hr),    32'h00);
    chk("rst_min",  32'(Set_Min),   32'h00);
    chk("rst_st",   32'(SetActive), 32'h0);
    chk("rst_bell", 32'(BellEn),    32'h1);
    nCR = 1'b1;
    tick(5);

    // bouncy Mode press: only the 30 ms stable part may count
    ModeKey = 1'b1; tick(1); ModeKey = 1'b0; tick(1);
    ModeKey = 1'b1; tick(1); ModeKey = 1'b0; tick(1);
    ModeKey = 1'b1; tick(1); ModeKey = 1'b0; tick(1);
    ModeKey = 1'b1; tick(15);
    chk("bounce_mid", 32'(SetActive), 32'h0);
    tick(15);
    chk("bounce_hr", 32'(SetActive), 32'h1);
    ModeKey = 1'b0; tick(40);
    chk("release_hr", 32'(SetActive), 32'h1);
    press(0, 15, 40);
    chk("short_press", 32'(SetActive), 32'h1);

    // 24 hour steps from 00 wrap back to 00
    for (int i = 1; i <= 24; i++) begin
      set_key(1, 1'b1);
      tick(50);
      v = i % 24;
      exp_bcd = 8'((v / 10) * 16 + (v % 10));
      chk($sformatf("hr_step%0d", i), 32'(Set_Hr), 32'(exp_bcd));
      set_key(1, 1'b0);
      tick(50);
    end
    chk("hr_min_hold", 32'(Set_Min), 32'h00);
    for (int i = 0; i < 12; i++) press(1, 50, 50);
    chk("hr_12", 32'(Set_Hr), 32'h12);

    press(0, 50, 50);
    chk("enter_min", 32'(SetActive), 32'h2);

    // Up held 2000 ms: press at +22, repeats at +1022/1272/1522/1772
    UpKey = 1'b1;
    tick(1000);
    chk("hold_1000", 32'(Set_Min), 32'h01);
    tick(30);
    chk("hold_1030", 32'(Set_Min), 32'h02);
    tick(970);
    UpKey = 1'b0;
    tick(50);
    chk("hold_done", 32'(Set_Min), 32'h05);

    for (int i = 0; i < 54; i++) press(1, 50, 50);
    chk("min_59", 32'(Set_Min), 32'h59);
    press(1, 50, 50);
    chk("min_wrap", 32'(Set_Min), 32'h00);
    chk("min_wrap_hr", 32'(Set_Hr), 32'h12);

    ModeKey = 1'b1; UpKey = 1'b1;
    tick(50);
    ModeKey = 1'b0; UpKey = 1'b0;
    tick(50);
    chk("same_cyc_st",  32'(SetActive), 32'h0);
    chk("same_cyc_min", 32'(Set_Min),   32'h00);
    chk("same_cyc_hr",  32'(Set_Hr),    32'h12);

    press(1, 50, 50);
    chk("idle_up_hr", 32'(Set_Hr), 32'h12);

    // timeout: IDLE exactly 10000 cycles after entering SET_HR
    ModeKey = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (SetActive == 2'b01) found = 1'b1;
    end
    chk("tmo_entry", 32'(found), 32'h1);
    ModeKey = 1'b0;
    tick(9999);
    chk("tmo_9999", 32'(SetActive), 32'h1);
    tick(1);
    chk("tmo_10000", 32'(SetActive), 32'h0);
    chk("tmo_hr", 32'(Set_Hr), 32'h12);

    press(2, 50, 50);
    chk("bell_off", 32'(BellEn), 32'h0);
    press(2, 50, 50);
    chk("bell_on", 32'(BellEn), 32'h1);
    press(2, 50, 50);
    chk("bell_off2", 32'(BellEn), 32'h0);

    press(0, 50, 50);
    press(0, 50, 50);
    chk("pre_rst_st", 32'(SetActive), 32'h2);

    // reset mid-debounce with Mode and Up held
    ModeKey = 1'b1; UpKey = 1'b1;
    tick(10);
    nCR = 1'b0;
    #1;
    chk("arst_hr",   32'(Set_Hr),    32'h00);
    chk("arst_min",  32'(Set_Min),   32'h00);
    chk("arst_st",   32'(SetActive), 32'h0);
    chk("arst_bell", 32'(BellEn),    32'h1);
    tick(5);
    nCR = 1'b1;
    tick(20);
    chk("post_rst_wait", 32'(SetActive), 32'h0);
    tick(10);
    chk("post_rst_st", 32'(SetActive), 32'h1);
    chk("post_rst_hr", 32'(Set_Hr), 32'h00);
    ModeKey = 1'b0; UpKey = 1'b0;
    tick(50);
    chk("post_rst_final", 32'(SetActive), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_set.md
ALARM_SET -- requirements
Module: alarm_set

Interface
REQ-001 Parameter DEB_MS, default 20: debounce interval in clock cycles (1 cycle = 1 ms).
REQ-002 Parameter HOLD_MS, default 1000: hold time before UpKey auto-repeat starts.
REQ-003 Parameter RPT_MS, default 250: auto-repeat period.
REQ-004 Parameter TMO_MS, default 10000: inactivity timeout in set mode.
REQ-005 _1kHzIN  input  1  sole clock, rising edge.
REQ-006 nCR  input  1  reset, asynchronous, active-low.
REQ-007 ModeKey  input  1  raw mode key, active-high, asynchronous to clock, bouncy.
REQ-008 UpKey  input  1  raw increment key, active-high, bouncy.
REQ-009 BellKey  input  1  raw bell enable/disable toggle key, active-high, bouncy.
REQ-010 Set_Hr  output  8  alarm hour, packed BCD 00..23.
REQ-011 Set_Min  output  8  alarm minute, packed BCD 00..59.
REQ-012 SetActive  output  2  current state: 00 IDLE, 01 SET_HR, 10 SET_MIN.
REQ-013 BellEn  output  1  alarm sound enable for the alarm block.

Function
REQ-014 Each raw key shall pass through a two-flop synchronizer followed by its own debounce counter.
REQ-015 Debounced level shall change only after the synchronized raw level differs from it for DEB_MS consecutive cycles; any mismatch gap shall restart the count.
REQ-016 A press event shall be a one-cycle pulse on the debounced 0->1 transition; release generates no event.
REQ-017 UpKey held debounced-high for HOLD_MS cycles after its press event shall produce a repeat pulse, then one every RPT_MS cycles until debounced release.
REQ-018 State machine: IDLE -ModeKey event-> SET_HR -ModeKey event-> SET_MIN -ModeKey event-> IDLE.
REQ-019 In SET_HR each UpKey press/repeat pulse shall increment Set_Hr in BCD: 09->10, 19->20, 23->00.
REQ-020 In SET_MIN each UpKey pulse shall increment Set_Min in BCD: x9->(x+1)0, 59->00; Set_Hr unchanged on minute wrap.
REQ-021 In IDLE, UpKey pulses shall be ignored; Set_Hr/Set_Min hold.
REQ-022 ModeKey event and UpKey pulse in the same cycle: state transition taken, increment discarded.
REQ-023 Timeout counter shall clear on any key event and on state entry; reaching TMO_MS cycles in SET_HR or SET_MIN shall force IDLE, values retained.
REQ-024 BellKey event shall toggle BellEn in any state, one cycle after the event pulse.
REQ-025 Register updates shall occur on the clock edge following the generating pulse; all outputs registered, no combinational path from key inputs to outputs.
REQ-026 Set_Hr/Set_Min shall never hold a non-BCD or out-of-range value.

Reset
REQ-027 nCR low shall immediately force Set_Hr=8'h00, Set_Min=8'h00, SetActive=2'b00, BellEn=1, all debounce, repeat and timeout counters and synchronizers to 0.
REQ-028 nCR asserted mid-debounce or mid-repeat shall discard the pending event; after release a key already held shall register only after a full DEB_MS stable interval.
REQ-029 nCR deassertion shall be taken synchronously into the clock domain; first event no earlier than the second edge after release.

Verification
REQ-030 Reset, ModeKey pulse 1 ms with 5 ms bounce then 30 ms stable -> exactly one transition IDLE->SET_HR; a 15 ms press -> no transition.
REQ-031 SET_HR, 24 separate UpKey presses (50 ms each) from 00 -> Set_Hr sequence 01..09,10..23,00, Set_Min stays 00.
REQ-032 SET_MIN, UpKey held 2000 ms -> 1 press + repeats at ~1020, 1270, 1520, 1770 ms after press start: Set_Min=8'h05.
REQ-033 SET_MIN at Set_Min=8'h59, one UpKey press -> Set_Min=8'h00, Set_Hr unchanged; ModeKey and UpKey debounced same cycle -> IDLE, no increment.
REQ-034 Enter SET_HR, no keys for 10000 cycles -> SetActive=00 on cycle 10000, Set_Hr retained; BellKey press -> BellEn 1->0, second press -> 1.
REQ-035 nCR pulsed low at Set_Hr=8'h12 in SET_MIN with UpKey held -> outputs 00/00/00/1 asynchronously, no increment for DEB_MS cycles after release.
